imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction ROM: receives a byte stream (e.g. from a UART RX), packs
//   every 3 bytes into one 24-bit instruction and writes it to instruction memory at
//   incrementing addresses. Holds the CPU core in reset (cpu_hold) while a program is loading.
// PARAMETERS
//   ADDR_W      8   instruction memory address width; capacity = 2**ADDR_W words
//   WORD_BYTES  3   bytes per instruction word (fixed at 3; word width = 8*WORD_BYTES = 24)
// PORTS
//   clk          in   1       system clock; all logic on rising edge
//   rst          in   1       synchronous, active-high reset
//   start        in   1       1-cycle pulse: begin a load (ignored while busy=1)
//   in_data      in   8       stream byte
//   in_valid     in   1       in_data valid
//   in_ready     out  1       loader accepts byte; transfer when in_valid & in_ready
//   mem_w_enable out  1       instruction memory write strobe (1 cycle per word)
//   mem_w_addr   out  ADDR_W  write address
//   mem_w_data   out  24      write data; first received byte in [23:16]
//   busy         out  1       load in progress
//   done         out  1       level: last load finished; cleared on next accepted start
//   err          out  1       level: last load failed/overflowed; cleared on accepted start
//   cpu_hold     out  1       hold CPU core in reset; equals busy
//   word_count   out  8       words written in current/last load
// BEHAVIOUR
//   - Reset: every output 0, FSM -> IDLE, internal count/addr/shift/checksum cleared.
//   - Stream format: LEN byte (N words, 0..255), then N*3 payload bytes MSB-first per word.
//   - IDLE: in_ready=0. start=1 -> LEN; busy=cpu_hold=1, done=err=0, word_count=0, addr=0.
//   - LEN: in_ready=1. On transfer: N=in_data. N==0 -> FIN. N > 2**ADDR_W -> err=1, FIN,
//     nothing written. Else -> BYTE, byte_idx=0.
//   - BYTE: in_ready=1. Each transfer shifts byte into 24-bit word; 3rd transfer -> WRITE.
//     in_valid low stalls indefinitely; no timeout.
//   - WRITE (1 cycle): in_ready=0, mem_w_enable=1 with mem_w_addr/mem_w_data stable that
//     cycle; then addr+1, word_count+1. word_count==N -> CHK (if enabled) else FIN; else BYTE.
//   - FIN (1 cycle): busy=cpu_hold=0, done=1 -> IDLE. done/err hold until next start.
//   - Throughput: 1 word per 4 cycles when in_valid held high. addr never wraps (N check).
//   - start while busy: ignored. Bytes presented in IDLE/WRITE/FIN: not accepted (in_ready=0).
//   - rst mid-load: immediate return to reset state; no further writes; words already
//     written remain in memory; partial word discarded.
//   - mem_w_addr/mem_w_data registered; mem_w_enable never high outside WRITE.
// CONFIGURATION
//   IMEM_LOADER_CHECKSUM_EN defined: after last word, state CHK (in_ready=1) accepts one
//     checksum byte = XOR of LEN byte and all payload bytes. Mismatch -> err=1; -> FIN.
//     N==0 also passes through CHK (checksum = LEN byte = 0x00). Written words not rolled back.
//   Not defined: no CHK state, no checksum logic; err only from length overflow.
// TESTING
//   1. start; bytes 02,11,22,33,44,55,66 -> writes [0]=112233, [1]=445566; done=1,
//      word_count=2, err=0, cpu_hold 1 from cycle after start until FIN.
//   2. Same stream with in_valid low 0-3 random cycles between bytes -> identical writes;
//      in_ready=0 in each WRITE cycle, exactly 2 mem_w_enable pulses.
//   3. start; LEN=00 -> no write, done=1 two cycles after LEN transfer, word_count=0.
//   4. start; 01,AA,BB then rst=1 one cycle -> no mem_w_enable, all outputs 0; new load
//      01,0A,0B,0C -> [0]=0A0B0C, done=1.
//   5. ADDR_W=2: LEN=05 -> err=1, done=1, no writes; start pulse mid-load ignored.
//   6. CHECKSUM_EN: 01,AA,BB,CC,DC -> [0]=AABBCC, err=0; repeat with last byte 00 -> err=1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction ROM writer: packs a LEN-prefixed byte stream into 24-bit words and holds the CPU in reset while loading.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that is checked before completion.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      mem_w_enable,
  output logic [ADDR_W-1:0]         mem_w_addr,
  output logic [8*WORD_BYTES-1:0]   mem_w_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      cpu_hold,
  output logic [7:0]                word_count
);

  localparam int          WORD_W   = 8 * WORD_BYTES;
  localparam logic [31:0] CAP      = 32'(1) << ADDR_W;
  localparam logic [1:0]  LAST_IDX = 2'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BYTE,
    S_WRITE,
    S_CHK,
    S_FIN
  } state_t;

  state_t                state;
  logic [7:0]            n_words;
  logic [1:0]            byte_idx;
  logic [ADDR_W-1:0]     addr;
  logic [WORD_W-9:0]     shift;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign mem_w_addr = addr;
  assign cpu_hold   = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      n_words      <= '0;
      byte_idx     <= '0;
      addr         <= '0;
      shift        <= '0;
      in_ready     <= 1'b0;
      mem_w_enable <= 1'b0;
      mem_w_data   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      word_count   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_w_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LEN;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            in_ready   <= 1'b1;
          end
        end

        S_LEN: begin
          if (in_valid) begin
            n_words <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= in_data;
`endif
            if (in_data == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              in_ready <= 1'b0;
              state    <= S_FIN;
`endif
            end else if ({24'd0, in_data} > CAP) begin
              // Reject before any write so addr can never wrap into earlier words.
              err      <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_FIN;
            end else begin
              byte_idx <= '0;
              state    <= S_BYTE;
            end
          end
        end

        S_BYTE: begin
          if (in_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            if (byte_idx == LAST_IDX) begin
              mem_w_data   <= {shift, in_data};
              mem_w_enable <= 1'b1;
              in_ready     <= 1'b0;
              byte_idx     <= '0;
              state        <= S_WRITE;
            end else begin
              shift    <= {shift[WORD_W-17:0], in_data};
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end

        S_WRITE: begin
          addr       <= addr + 1'b1;
          word_count <= word_count + 8'd1;
          if (word_count + 8'd1 == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready <= 1'b1;
            state    <= S_CHK;
`else
            state    <= S_FIN;
`endif
          end else begin
            in_ready <= 1'b1;
            state    <= S_BYTE;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (in_valid) begin
            // Words already written stay in memory; only the error flag reports the mismatch.
            if (in_data != csum) err <= 1'b1;
            in_ready <= 1'b0;
            state    <= S_FIN;
          end
        end
`endif

        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader (ADDR_W=2) against a stream-level reference model.
module tb_imem_loader;
  localparam int ADDR_W = 2;
  localparam int CAP    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_w_enable;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [23:0]       mem_w_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;
  logic [7:0]        word_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [23:0]       wd_q[$];
  int                wc_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .WORD_BYTES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_w_enable(mem_w_enable), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .busy(busy), .done(done), .err(err),
    .cpu_hold(cpu_hold), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write monitor: records every strobe and checks no byte is accepted in that cycle.
  always @(negedge clk) begin
    cyc++;
    if (mem_w_enable === 1'b1) begin
      wa_q.push_back(mem_w_addr);
      wd_q.push_back(mem_w_data);
      wc_q.push_back(cyc);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL write_in_ready: in_ready=%b during write, required 0", in_ready);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int i;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    i = 0;
    while (in_ready !== 1'b1 && i < 64) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (in_ready === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
    end else begin
      miscompares++;
      $display("FAIL send_byte_timeout: in_ready=%b after 64 cycles, required 1", in_ready);
    end
    in_valid = 1'b0;
  endtask

  // cs_mode: 0 append correct checksum, 1 stream already complete, 2 append wrong checksum.
  task automatic run_load(input logic [7:0] base[$], input int cs_mode, input int maxgap,
                          input int mid_start, input string name);
    logic [7:0] s[$];
    int         n;
    logic       exp_err;
    int         exp_wc;
    int         k;
    logic [23:0] exp_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs;
`endif
    s       = base;
    n       = int'(s[0]);
    exp_err = 1'b0;
    exp_wc  = 0;
    if (n > CAP) begin
      exp_err = 1'b1;
    end else begin
      exp_wc = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cs = 8'd0;
      for (int i = 0; i <= 3 * n; i++) cs ^= s[i];
      if (cs_mode == 0) s.push_back(cs);
      else if (cs_mode == 2) s.push_back(cs ^ 8'h5A);
      if (s[3 * n + 1] !== cs) exp_err = 1'b1;
`else
      if (cs_mode == 1 && s.size() > 3 * n + 1) s.pop_back();
`endif
    end
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || word_count !== 8'd0) begin
      miscompares++;
      $display("FAIL %s_after_start: hold=%b busy=%b done=%b err=%b wc=%0d, required 1 1 0 0 0",
               name, cpu_hold, busy, done, err, word_count);
    end

    for (int i = 0; i < s.size(); i++) begin
      if (i == mid_start) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(s[i], $urandom_range(0, maxgap));
    end

    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end

    vectors++;
    if (wa_q.size() != exp_wc) begin
      miscompares++;
      $display("FAIL %s_write_count: got %0d writes, required %0d", name, wa_q.size(), exp_wc);
    end else begin
      for (int w = 0; w < exp_wc; w++) begin
        exp_d = {s[1 + 3 * w], s[2 + 3 * w], s[3 + 3 * w]};
        vectors++;
        if (wa_q[w] !== ADDR_W'(w) || wd_q[w] !== exp_d) begin
          miscompares++;
          $display("FAIL %s_write%0d: got [%0d]=%06h, required [%0d]=%06h",
                   name, w, wa_q[w], wd_q[w], w, exp_d);
        end
      end
    end
    vectors++;
    if (done !== 1'b1 || err !== exp_err || word_count !== 8'(exp_wc) ||
        busy !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_final: done=%b err=%b wc=%0d busy=%b hold=%b rdy=%b, required 1 %b %0d 0 0 0",
               name, done, err, word_count, busy, cpu_hold, in_ready, exp_err, exp_wc);
    end
  endtask

  task automatic check_idle_zero(input string name);
    vectors++;
    if (in_ready !== 1'b0 || mem_w_enable !== 1'b0 || mem_w_addr !== '0 || mem_w_data !== 24'd0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b0 || word_count !== 8'd0) begin
      miscompares++;
      $display("FAIL %s: rdy=%b we=%b addr=%0d data=%06h busy=%b done=%b err=%b hold=%b wc=%0d, required all 0",
               name, in_ready, mem_w_enable, mem_w_addr, mem_w_data, busy, done, err, cpu_hold, word_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("idle_after_reset");
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load(s, 0, 0, -1, "basic");
    vectors++;
    if (wc_q.size() != 2 || wc_q[1] - wc_q[0] != 4) begin
      miscompares++;
      $display("FAIL throughput: write spacing %0d cycles, required 4",
               (wc_q.size() == 2) ? wc_q[1] - wc_q[0] : -1);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] s[$];
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int r = 0; r < 3; r++) run_load(s, 0, 3, -1, "gaps");
  endtask

  task automatic test_len_zero();
    wa_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_fin_cycle: done=%b busy=%b, required 0 1", done, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0 || err !== 1'b0 ||
        word_count !== 8'd0 || wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL len0_done: done=%b busy=%b hold=%b err=%b wc=%0d writes=%0d, required 1 0 0 0 0 0",
               done, busy, cpu_hold, err, word_count, wa_q.size());
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] s[$];
    wa_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rst_mid_outputs");
    repeat (3) @(negedge clk);
    vectors++;
    if (wa_q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_writes: got %0d writes, required 0", wa_q.size());
    end
    s = '{8'h01, 8'h0A, 8'h0B, 8'h0C};
    run_load(s, 0, 1, -1, "after_rst");
  endtask

  task automatic test_overflow();
    logic [7:0] s[$];
    s = '{8'h05};
    run_load(s, 0, 0, -1, "overflow");
    s = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
          8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    run_load(s, 0, 1, -1, "full_cap");
  endtask

  task automatic test_start_ignored();
    logic [7:0] s[$];
    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_load(s, 0, 0, 3, "start_ignored");
  endtask

  task automatic test_checksum();
    logic [7:0] s[$];
    s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDC};
    run_load(s, 1, 0, -1, "csum_good");
    s = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    run_load(s, 1, 0, -1, "csum_bad");
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    int n;
    for (int r = 0; r < 20; r++) begin
      s.delete();
      n = $urandom_range(0, CAP + 1);
      s.push_back(8'(n));
      if (n <= CAP)
        for (int i = 0; i < 3 * n; i++) s.push_back(8'($urandom_range(0, 255)));
      run_load(s, ($urandom_range(0, 3) == 0) ? 2 : 0, 3, -1, "random");
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_len_zero();
    test_rst_mid();
    test_overflow();
    test_start_ignored();
    test_checksum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
